// File: rtl/cpu_mem_pkg.sv
// ----------------------------------------------------------------------------
// cpu_mem_pkg
// Shared definitions for the CPU main-memory side: the fill arbiter state
// encoding, the block word-offset width and the fill owner encoding.
// No ports (package).
// ----------------------------------------------------------------------------
package cpu_mem_pkg;

    // Arbiter states. The encoding is fixed so the hazard unit and debug
    // logic can decode the state directly.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        FILL  = 2'b10,
        DONE  = 2'b11
    } arb_state_t;

    // 8 sixteen-bit words per 16-byte block.
    localparam int BLOCK_OFFSET_W = 3;

    // Which cache a block fill belongs to.
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } fill_owner_t;

endpackage

// File: rtl/fill_counter.sv
// ----------------------------------------------------------------------------
// fill_counter
// Word counter for one side of a block fill (issue or receive). Counts
// accepted events from 0 up to the last word of the block and then raises a
// sticky done flag that blocks further counting until cleared.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   clear  - synchronous clear of count and done
//   inc    - count one event this cycle
//   count  - current word index (wraps to 0 when the block completes)
//   done   - all words of the block have been counted
// ----------------------------------------------------------------------------
module fill_counter
    import cpu_mem_pkg::*;
#(
    parameter int W = BLOCK_OFFSET_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         done
);

    // The counter wraps to zero at the block end; done remembers that the
    // wrap happened so the owner knows the whole block has been counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            done  <= 1'b0;
        end else if (clear) begin
            count <= '0;
            done  <= 1'b0;
        end else if (inc && !done) begin
            count <= count + 1'b1;
            if (count == '1) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_fill_arbiter.sv
// ----------------------------------------------------------------------------
// cache_fill_arbiter
// Owns the single main-memory port. Arbitrates between write-through stores,
// D-cache misses and I-cache misses (in that priority order), performs the
// one-cycle store, and sequences 8-word block fills into the requesting
// cache. busy is high whenever the port is owned so the pipeline can stall.
//
// Build option: CRIT_WORD_FIRST_EN - when defined, a fill starts at the
// missing word and wraps around the block; otherwise it starts at word 0.
//
// Ports:
//   clk, rst_n            - clock (rising edge), async active-low reset
//   i_miss, i_miss_addr   - I-cache miss request and byte address
//   d_miss, d_miss_addr   - D-cache miss request and byte address
//   d_wr_req/addr/data    - write-through store request
//   mem_en/wr/addr/wdata  - memory command port
//   mem_rdata, mem_data_valid - memory read return
//   i_fill_we, d_fill_we  - fill write strobes into each cache
//   fill_word, fill_data  - word offset and data of the current fill beat
//   i_fill_done, d_fill_done, d_wr_ack - completion pulses
//   busy                  - memory port owned
// ----------------------------------------------------------------------------
module cache_fill_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4,
    parameter int ADDR_W          = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_miss,
    input  logic [ADDR_W-1:0]         i_miss_addr,
    input  logic                      d_miss,
    input  logic [ADDR_W-1:0]         d_miss_addr,
    input  logic                      d_wr_req,
    input  logic [ADDR_W-1:0]         d_wr_addr,
    input  logic [15:0]               d_wr_data,
    output logic                      mem_en,
    output logic                      mem_wr,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [15:0]               mem_wdata,
    input  logic [15:0]               mem_rdata,
    input  logic                      mem_data_valid,
    output logic                      i_fill_we,
    output logic                      d_fill_we,
    output logic [BLOCK_OFFSET_W-1:0] fill_word,
    output logic [15:0]               fill_data,
    output logic                      i_fill_done,
    output logic                      d_fill_done,
    output logic                      d_wr_ack,
    output logic                      busy
);

    // The block counters are fixed at 3 bits and the receive side only
    // counts valid beats, so any other block size or a zero latency memory
    // is not a supported configuration.
    if (WORDS_PER_BLOCK != (1 << BLOCK_OFFSET_W) || MEM_LATENCY < 1) begin : g_bad_cfg
        $error("cache_fill_arbiter: unsupported WORDS_PER_BLOCK or MEM_LATENCY");
    end

    arb_state_t                state, state_nx;
    fill_owner_t               owner, owner_nx;
    logic [ADDR_W-1:4]         blk_tag, blk_tag_nx;
    logic [BLOCK_OFFSET_W-1:0] start, start_nx;
    logic [BLOCK_OFFSET_W-1:0] i_start, d_start;
    logic [BLOCK_OFFSET_W-1:0] ic_count, rc_count;
    logic [BLOCK_OFFSET_W-1:0] issue_off, recv_off;
    logic                      ic_done, rc_done;
    logic                      issue_active, rx_beat, cnt_clear;
    logic                      unused_addr_bits;

    // Start word of a new fill: the missing word itself when critical word
    // first is built in, otherwise always the first word of the block.
`ifdef CRIT_WORD_FIRST_EN
    assign i_start          = i_miss_addr[3:1];
    assign d_start          = d_miss_addr[3:1];
    assign unused_addr_bits = ^{i_miss_addr[0], d_miss_addr[0]};
`else
    assign i_start          = '0;
    assign d_start          = '0;
    assign unused_addr_bits = ^{i_miss_addr[3:0], d_miss_addr[3:0]};
`endif

    // A read is issued every FILL cycle until all eight have gone out; a
    // beat is accepted only in FILL, so stray returns elsewhere are dropped.
    assign issue_active = (state == FILL) && !ic_done;
    assign rx_beat      = (state == FILL) && mem_data_valid && !rc_done;
    assign cnt_clear    = (state != FILL);
    assign issue_off    = start + ic_count;
    assign recv_off     = start + rc_count;

    fill_counter #(.W(BLOCK_OFFSET_W)) u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .inc   (issue_active),
        .count (ic_count),
        .done  (ic_done)
    );

    fill_counter #(.W(BLOCK_OFFSET_W)) u_recv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .inc   (rx_beat),
        .count (rc_count),
        .done  (rc_done)
    );

    // State and fill context registers. Owner, block tag and start word are
    // captured once when a fill is granted and then held, so the request
    // inputs may change freely while the fill runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= OWN_I;
            blk_tag <= '0;
            start   <= '0;
        end else begin
            state   <= state_nx;
            owner   <= owner_nx;
            blk_tag <= blk_tag_nx;
            start   <= start_nx;
        end
    end

    // Next-state logic. Arbitration happens only in IDLE, so anything that
    // arrives while the port is owned simply waits; after DONE there is
    // always one IDLE cycle before the next grant.
    always_comb begin
        state_nx   = state;
        owner_nx   = owner;
        blk_tag_nx = blk_tag;
        start_nx   = start;
        unique case (state)
            IDLE: begin
                if (d_wr_req) begin
                    state_nx = WRITE;
                end else if (d_miss) begin
                    state_nx   = FILL;
                    owner_nx   = OWN_D;
                    blk_tag_nx = d_miss_addr[ADDR_W-1:4];
                    start_nx   = d_start;
                end else if (i_miss) begin
                    state_nx   = FILL;
                    owner_nx   = OWN_I;
                    blk_tag_nx = i_miss_addr[ADDR_W-1:4];
                    start_nx   = i_start;
                end
            end
            WRITE: state_nx = IDLE;
            FILL: begin
                if (rx_beat && rc_count == '1) begin
                    state_nx = DONE;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode. Everything is forced to zero outside the states that
    // use it, so an asynchronous reset clears every output immediately.
    always_comb begin
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        i_fill_we   = 1'b0;
        d_fill_we   = 1'b0;
        fill_word   = '0;
        fill_data   = '0;
        i_fill_done = 1'b0;
        d_fill_done = 1'b0;
        d_wr_ack    = 1'b0;
        busy        = (state != IDLE);
        if (state == WRITE) begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = d_wr_addr;
            mem_wdata = d_wr_data;
            d_wr_ack  = 1'b1;
        end
        if (issue_active) begin
            mem_en   = 1'b1;
            mem_addr = {blk_tag, issue_off, 1'b0};
        end
        if (state == FILL) begin
            fill_word = recv_off;
            fill_data = mem_rdata;
            i_fill_we = rx_beat && (owner == OWN_I);
            d_fill_we = rx_beat && (owner == OWN_D);
        end
        if (state == DONE) begin
            i_fill_done = (owner == OWN_I);
            d_fill_done = (owner == OWN_D);
        end
    end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cache_fill_arbiter
// Self-checking bench for cache_fill_arbiter. A 4-cycle pipelined memory
// model answers reads with address-derived data. For each scenario a
// timeline model builds the expected value of every output on every cycle
// from the arbitration and fill timing rules, and the DUT is compared
// against it cycle by cycle.
// ----------------------------------------------------------------------------
module tb_cache_fill_arbiter;

    localparam int WORDS     = 8;
    localparam int LAT       = 4;
    localparam int FILL_CYC  = WORDS + LAT;     // cycles spent in FILL
    localparam int EXP_DEPTH = 96;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_miss, d_miss, d_wr_req;
    logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_data_valid;
    logic        i_fill_we, d_fill_we;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        i_fill_done, d_fill_done, d_wr_ack, busy;

    typedef struct packed {
        logic        mem_en;
        logic        mem_wr;
        logic [15:0] mem_addr;
        logic [15:0] mem_wdata;
        logic        i_we;
        logic        d_we;
        logic [2:0]  word;
        logic [15:0] data;
        logic        i_done;
        logic        d_done;
        logic        ack;
        logic        busy;
    } obs_t;

    obs_t        exp_q [EXP_DEPTH];
    obs_t        got;
    int          checks = 0;
    int          fails  = 0;
    int          hz;

    // Requests of the current scenario: which ones exist, the cycle each is
    // raised, and their addresses/data.
    bit          want_wr, want_d, want_i;
    int          at_wr, at_d, at_i;
    logic [15:0] m_wr_addr, m_wr_data, m_d_addr, m_i_addr;

    // Memory model state.
    logic [3:0]  pipe_v = '0;
    logic [15:0] pipe_a [4] = '{default: 16'h0};
    logic        inject_valid = 1'b0;
    logic [15:0] mem_key = 16'h0;

    always #5 clk = ~clk;

    cache_fill_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_miss         (i_miss),
        .i_miss_addr    (i_miss_addr),
        .d_miss         (d_miss),
        .d_miss_addr    (d_miss_addr),
        .d_wr_req       (d_wr_req),
        .d_wr_addr      (d_wr_addr),
        .d_wr_data      (d_wr_data),
        .mem_en         (mem_en),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_data_valid (mem_data_valid),
        .i_fill_we      (i_fill_we),
        .d_fill_we      (d_fill_we),
        .fill_word      (fill_word),
        .fill_data      (fill_data),
        .i_fill_done    (i_fill_done),
        .d_fill_done    (d_fill_done),
        .d_wr_ack       (d_wr_ack),
        .busy           (busy)
    );

    // Memory contents: word k of block 0x00xx reads 16'hA000+k; the upper
    // address byte and a per-scenario key make other blocks distinct.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return ((16'hA000 ^ {a[15:8], 8'h00}) ^ mem_key) + {13'd0, a[3:1]};
    endfunction

    // Pipelined memory: a read accepted at a rising edge returns four
    // cycles after the cycle in which it was issued.
    always @(posedge clk) begin
        pipe_v    <= {pipe_v[2:0], mem_en & ~mem_wr};
        pipe_a[0] <= mem_addr;
        pipe_a[1] <= pipe_a[0];
        pipe_a[2] <= pipe_a[1];
        pipe_a[3] <= pipe_a[2];
    end

    assign mem_data_valid = pipe_v[3] | inject_valid;
    assign mem_rdata      = pipe_v[3] ? mem_word(pipe_a[3]) : 16'h0;

    function automatic obs_t sample();
        obs_t o;
        o.mem_en    = mem_en;
        o.mem_wr    = mem_wr;
        o.mem_addr  = mem_addr;
        o.mem_wdata = mem_wdata;
        o.i_we      = i_fill_we;
        o.d_we      = d_fill_we;
        o.word      = fill_word;
        o.data      = fill_data;
        o.i_done    = i_fill_done;
        o.d_done    = d_fill_done;
        o.ack       = d_wr_ack;
        o.busy      = busy;
        return o;
    endfunction

    // Expected outputs of one block fill granted in IDLE cycle t.
    task automatic add_fill(input int t, input bit is_d, input logic [15:0] addr);
        logic [15:0] base, wa;
        logic [2:0]  start, w;
        base = {addr[15:4], 4'h0};
`ifdef CRIT_WORD_FIRST_EN
        start = addr[3:1];
`else
        start = 3'd0;
`endif
        for (int k = 0; k < WORDS; k++) begin
            w  = start + 3'(k);
            wa = base | {12'd0, w, 1'b0};
            exp_q[t + 1 + k].mem_en   = 1'b1;
            exp_q[t + 1 + k].mem_addr = wa;
            exp_q[t + 1 + LAT + k].i_we = !is_d;
            exp_q[t + 1 + LAT + k].d_we = is_d;
            exp_q[t + 1 + LAT + k].word = w;
            exp_q[t + 1 + LAT + k].data = mem_word(wa);
        end
        for (int c = t + 1; c <= t + FILL_CYC + 1; c++) exp_q[c].busy = 1'b1;
        exp_q[t + FILL_CYC + 1].i_done = !is_d;
        exp_q[t + FILL_CYC + 1].d_done = is_d;
    endtask

    // Timeline model: in each IDLE cycle grant the highest-priority request
    // already raised (store > D miss > I miss); a store takes one cycle, a
    // fill takes FILL_CYC cycles plus DONE, and each is followed by IDLE.
    task automatic build_expect(output int horizon);
        int t;
        bit s_wr, s_d, s_i;
        for (int c = 0; c < EXP_DEPTH; c++) exp_q[c] = '0;
        t = 0;
        s_wr = !want_wr;
        s_d  = !want_d;
        s_i  = !want_i;
        while (!(s_wr && s_d && s_i)) begin
            if (!s_wr && at_wr <= t) begin
                exp_q[t + 1].mem_en    = 1'b1;
                exp_q[t + 1].mem_wr    = 1'b1;
                exp_q[t + 1].mem_addr  = m_wr_addr;
                exp_q[t + 1].mem_wdata = m_wr_data;
                exp_q[t + 1].ack       = 1'b1;
                exp_q[t + 1].busy      = 1'b1;
                s_wr = 1'b1;
                t    = t + 2;
            end else if (!s_d && at_d <= t) begin
                add_fill(t, 1'b1, m_d_addr);
                s_d = 1'b1;
                t   = t + FILL_CYC + 2;
            end else if (!s_i && at_i <= t) begin
                add_fill(t, 1'b0, m_i_addr);
                s_i = 1'b1;
                t   = t + FILL_CYC + 2;
            end else begin
                t = t + 1;
            end
        end
        horizon = t + 1;
    endtask

    // Requestor behaviour: raise each request on its cycle, hold it until
    // its completion pulse is seen.
    task automatic raise_requests(input int c);
        if (want_wr && at_wr == c) begin
            d_wr_req  = 1'b1;
            d_wr_addr = m_wr_addr;
            d_wr_data = m_wr_data;
        end
        if (want_d && at_d == c) begin
            d_miss      = 1'b1;
            d_miss_addr = m_d_addr;
        end
        if (want_i && at_i == c) begin
            i_miss      = 1'b1;
            i_miss_addr = m_i_addr;
        end
    endtask

    task automatic drop_requests();
        if (d_wr_ack)    d_wr_req = 1'b0;
        if (d_fill_done) d_miss   = 1'b0;
        if (i_fill_done) i_miss   = 1'b0;
    endtask

    task automatic set_reqs(input bit w, input bit d, input bit i,
                            input int aw, input int ad, input int ai);
        want_wr = w; want_d = d; want_i = i;
        at_wr = aw;  at_d = ad;  at_i = ai;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        i_miss = 1'b0; d_miss = 1'b0; d_wr_req = 1'b0;
        i_miss_addr = '0; d_miss_addr = '0; d_wr_addr = '0; d_wr_data = '0;
        #1 rst_n = 1'b0;
        #2;
        got = sample();
        checks++;
        if (got !== obs_t'(0)) begin
            fails++;
            $display("[TB] FAIL reset_state got %h want %h", got, obs_t'(0));
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #2;
            got = sample();
            checks++;
            if (got !== obs_t'(0)) begin
                fails++;
                $display("[TB] FAIL idle_after_reset cycle %0d got %h want %h", c, got, obs_t'(0));
            end
        end
    endtask

    task automatic test_i_fill();
        set_reqs(1'b0, 1'b0, 1'b1, 0, 0, 0);
        mem_key = 16'h0; m_i_addr = 16'h0046;
        build_expect(hz);
        @(posedge clk); #1;
        for (int c = 0; c < hz; c++) begin
            raise_requests(c); #1;
            got = sample();
            checks++;
            if (got !== exp_q[c]) begin
                fails++;
                $display("[TB] FAIL i_fill cycle %0d got %h want %h", c, got, exp_q[c]);
            end
            drop_requests();
            if (c == 3) i_miss_addr = 16'hFFFE;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_simultaneous_miss();
        set_reqs(1'b0, 1'b1, 1'b1, 0, 0, 0);
        m_d_addr = 16'h1000; m_i_addr = 16'h2000;
        build_expect(hz);
        for (int c = 0; c < hz; c++) begin
            raise_requests(c); #1;
            got = sample();
            checks++;
            if (got !== exp_q[c]) begin
                fails++;
                $display("[TB] FAIL simul_miss cycle %0d got %h want %h", c, got, exp_q[c]);
            end
            drop_requests();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_write_then_fill();
        set_reqs(1'b1, 1'b1, 1'b0, 0, 0, 0);
        m_wr_addr = 16'h3002; m_wr_data = 16'hBEEF; m_d_addr = 16'h0A10;
        build_expect(hz);
        for (int c = 0; c < hz; c++) begin
            raise_requests(c); #1;
            got = sample();
            checks++;
            if (got !== exp_q[c]) begin
                fails++;
                $display("[TB] FAIL write_then_fill cycle %0d got %h want %h", c, got, exp_q[c]);
            end
            drop_requests();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_crit_word();
        set_reqs(1'b0, 1'b1, 1'b0, 0, 0, 0);
        m_d_addr = 16'h004A;
        build_expect(hz);
        for (int c = 0; c < hz; c++) begin
            raise_requests(c); #1;
            got = sample();
            checks++;
            if (got !== exp_q[c]) begin
                fails++;
                $display("[TB] FAIL crit_word cycle %0d got %h want %h", c, got, exp_q[c]);
            end
            drop_requests();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wr_during_fill();
        set_reqs(1'b1, 1'b0, 1'b1, 3, 0, 0);
        m_i_addr = 16'h5554; m_wr_addr = 16'h7F00; m_wr_data = 16'h1234;
        build_expect(hz);
        for (int c = 0; c < hz; c++) begin
            raise_requests(c); #1;
            got = sample();
            checks++;
            if (got !== exp_q[c]) begin
                fails++;
                $display("[TB] FAIL wr_during_fill cycle %0d got %h want %h", c, got, exp_q[c]);
            end
            drop_requests();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mid_reset();
        set_reqs(1'b0, 1'b0, 1'b1, 0, 0, 0);
        m_i_addr = 16'h0120;
        build_expect(hz);
        for (int c = 0; c < 6; c++) begin
            raise_requests(c); #1;
            got = sample();
            checks++;
            if (got !== exp_q[c]) begin
                fails++;
                $display("[TB] FAIL mid_reset_pre cycle %0d got %h want %h", c, got, exp_q[c]);
            end
            drop_requests();
            @(posedge clk); #1;
        end
        rst_n  = 1'b0;
        i_miss = 1'b0;
        #1;
        got = sample();
        checks++;
        if (got !== obs_t'(0)) begin
            fails++;
            $display("[TB] FAIL reset_async got %h want %h", got, obs_t'(0));
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 8; c < 20; c++) begin
            @(posedge clk); #1;
            inject_valid = (c == 12 || c == 13);
            #1;
            got = sample();
            checks++;
            if (got !== obs_t'(0)) begin
                fails++;
                $display("[TB] FAIL post_reset_idle cycle %0d got %h want %h", c, got, obs_t'(0));
            end
        end
        inject_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int sel;
        for (int it = 0; it < 16; it++) begin
            sel = int'($urandom_range(1, 7));
            set_reqs(sel[2], sel[1], sel[0], int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            m_wr_addr = 16'($urandom);
            m_wr_data = 16'($urandom);
            m_d_addr  = 16'($urandom);
            m_i_addr  = 16'($urandom);
            mem_key   = 16'($urandom);
            build_expect(hz);
            for (int c = 0; c < hz; c++) begin
                raise_requests(c); #1;
                got = sample();
                checks++;
                if (got !== exp_q[c]) begin
                    fails++;
                    $display("[TB] FAIL random it %0d cycle %0d got %h want %h", it, c, got, exp_q[c]);
                end
                drop_requests();
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_i_fill();
        test_simultaneous_miss();
        test_write_then_fill();
        test_crit_word();
        test_wr_during_fill();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
